mod_addsub_pipe: RTL
====================

// Module: mod_addsub_pipe
// PURPOSE
//  Pipelined, multi-lane modular adder/subtractor for the NTT datapath. Per lane computes
//  (a+b) mod q or (a-b) mod q, selected per transaction. Two-stage pipeline with
//  valid/ready backpressure; sits between butterfly operand fetch and the result writeback.
// PARAMETERS
//  WIDTH   64  operand/modulus width in bits (>=2)
//  LANES   4   independent lanes, sharing one handshake, one op and one modulus
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst        in   1            synchronous reset, active-high
//  in_valid   in   1            input beat valid
//  in_ready   out  1            block accepts beat this cycle
//  in_op      in   1            0 = add, 1 = subtract (a - b)
//  in_q       in   WIDTH        modulus, captured with the beat
//  in_a       in   LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
//  in_b       in   LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
//  out_valid  out  1            result beat valid
//  out_ready  in   1            downstream accepts result
//  out_data   out  LANES*WIDTH  reduced results, same lane packing
//  out_err    out  LANES        range-check flags (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_err=0, both stage valid flags cleared; in-flight
//    beats discarded when rst is asserted mid-operation; in_ready=1 in the cycle after rst drops.
//  - Handshake: transfer when valid&&ready on a port. in_ready = !s2_valid || out_ready
//    (single global advance enable). out_valid/out_data held stable while out_valid&&!out_ready.
//    in_ready is not a function of in_valid.
//  - Stage 1 (on accept): register op, q and per-lane W+1-bit raw value:
//    add: r = {0,a}+{0,b}; sub: r = {0,a}-{0,b} (bit WIDTH = borrow).
//  - Stage 2: add: out = (r >= {0,q}) ? r-{0,q} : r; sub: out = r[WIDTH] ? r+{0,q} : r;
//    all intermediate W+1 bits, truncated to WIDTH at output. No multiply, no loop.
//  - Latency: beat accepted in cycle t -> out_valid in cycle t+2 when out_ready held 1.
//    Throughput 1 beat/cycle with no stall; bubbles propagate, never duplicated or dropped.
//  - Stall: when out_ready=0 and s2 full, whole pipe freezes (s1 holds, in_ready=0).
//  - Simultaneous out transfer and new input in same cycle: both occur, no bubble.
//  - Operands must satisfy a,b < q for mathematically correct results; out-of-range operands
//    still yield the deterministic formula above. q=0 is illegal (result unspecified).
//  - Lanes fully independent arithmetically; handshake common to all lanes.
// CONFIGURATION
//  MOD_ADDSUB_RANGE_CHK_EN
//  - defined: stage 1 also registers per-lane flag (a >= q) || (b >= q); out_err[i] travels
//    with its beat, valid only when out_valid=1; cleared by rst.
//  - undefined: no comparators built; out_err tied to 0.
// TESTING (WIDTH=64, LANES=4, q=0xFFFFFFFF00000001 unless noted)
//  1 add, a=q-1,b=1 (all lanes) -> out=0 in all lanes, out_valid exactly 2 cycles after accept
//  2 sub, a=3,b=5 -> out=q-2=0xFFFFFFFEFFFFFFFF; sub a=7,b=7 -> 0; add a=q-1,b=q-1 -> q-2
//  3 stream 16 random beats, out_ready toggling 1/0 pseudo-randomly -> results match
//    reference model in order, no drops/duplicates, out_data stable during stall
//  4 out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after 2 beats buffered; release
//    -> beats emerge in order, one per cycle
//  5 rst asserted with 2 beats in flight -> next cycle out_valid=0, out_data=0; no stale beat
//  6 RANGE_CHK_EN: lane 2 a=q -> out_err=4'b0100; macro off -> out_err=0; WIDTH=8,q=251 add
//    250+250 -> 249

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// ---------------------------------------------------------------------------------------------
// mod_addsub_pipe
//   Two-stage, multi-lane modular adder/subtractor for the NTT datapath. Every lane computes
//   (a + b) mod q or (a - b) mod q. All lanes share one operation select, one modulus and one
//   valid/ready handshake. The pipeline advances as a whole whenever the output stage is empty
//   or is being drained, so a stalled output freezes both stages.
//
//   Stage 1 captures the op, the modulus and the raw WIDTH+1-bit sum/difference of each lane.
//   Stage 2 applies a single conditional correction by q and holds the result for the consumer.
//
// Parameters
//   WIDTH      operand / modulus width in bits (>= 2)
//   LANES      number of independent arithmetic lanes
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   input beat valid
//   in_ready   input beat accepted this cycle (does not depend on in_valid)
//   in_op      0 = add, 1 = subtract (a - b)
//   in_q       modulus, captured with the beat
//   in_a/in_b  operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid  result beat valid
//   out_ready  consumer accepts the result beat
//   out_data   reduced results, same lane packing as the operands
//   out_err    per-lane range flag (a >= q) || (b >= q), travels with its beat
//
// Build option
//   MOD_ADDSUB_RANGE_CHK_EN  when defined, stage 1 builds per-lane range comparators and
//                            out_err reports them; otherwise out_err is constant zero.
// ---------------------------------------------------------------------------------------------
module mod_addsub_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_op,
    input  logic [WIDTH-1:0]       in_q,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_err
);

    // Single global advance enable: both stages move together.
    logic w_adv;

    logic                        r_s1_valid;
    logic                        r_s1_op;
    logic [WIDTH-1:0]            r_s1_q;
    logic [LANES-1:0][WIDTH:0]   r_s1_raw;

    logic                        r_s2_valid;
    logic [LANES*WIDTH-1:0]      r_s2_data;

    logic [LANES-1:0][WIDTH:0]   w_raw;
    logic [LANES-1:0][WIDTH:0]   w_red;
    logic [WIDTH:0]              w_qx;
    logic [LANES*WIDTH-1:0]      w_out;
    logic [LANES-1:0]            w_unused_red_msb;

    assign w_adv    = !r_s2_valid || out_ready;
    assign in_ready = w_adv;

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;

    // Stage 1 arithmetic: bit WIDTH is the carry for add and the borrow for subtract.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_op) begin
                w_raw[i] = {1'b0, in_a[i*WIDTH +: WIDTH]} - {1'b0, in_b[i*WIDTH +: WIDTH]};
            end else begin
                w_raw[i] = {1'b0, in_a[i*WIDTH +: WIDTH]} + {1'b0, in_b[i*WIDTH +: WIDTH]};
            end
        end
    end

    // Stage 2 correction: at most one add or subtract of q is ever needed.
    assign w_qx = {1'b0, r_s1_q};

    always_comb begin
        w_red            = '0;
        w_out            = '0;
        w_unused_red_msb = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_s1_op) begin
                w_red[i] = r_s1_raw[i][WIDTH] ? (r_s1_raw[i] + w_qx) : r_s1_raw[i];
            end else begin
                w_red[i] = (r_s1_raw[i] >= w_qx) ? (r_s1_raw[i] - w_qx) : r_s1_raw[i];
            end
            w_out[i*WIDTH +: WIDTH] = w_red[i][WIDTH-1:0];
            // The correction wraps the extra bit away; it carries no information.
            w_unused_red_msb[i]     = w_red[i][WIDTH];
        end
    end

    // Pipeline valid flags and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            // Bubbles leave the last result in place rather than loading garbage.
            if (r_s1_valid) begin
                r_s2_data <= w_out;
            end
        end
    end

    // Stage 1 payload, loaded only on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_op  <= 1'b0;
            r_s1_q   <= '0;
            r_s1_raw <= '0;
        end else if (w_adv && in_valid) begin
            r_s1_op  <= in_op;
            r_s1_q   <= in_q;
            r_s1_raw <= w_raw;
        end
    end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    logic [LANES-1:0] w_err;
    logic [LANES-1:0] r_s1_err;
    logic [LANES-1:0] r_s2_err;

    always_comb begin
        w_err = '0;
        for (int i = 0; i < LANES; i++) begin
            w_err[i] = (in_a[i*WIDTH +: WIDTH] >= in_q) || (in_b[i*WIDTH +: WIDTH] >= in_q);
        end
    end

    // Flags follow exactly the same load conditions as the data they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_err <= '0;
            r_s2_err <= '0;
        end else if (w_adv) begin
            if (in_valid) begin
                r_s1_err <= w_err;
            end
            if (r_s1_valid) begin
                r_s2_err <= r_s1_err;
            end
        end
    end

    assign out_err = r_s2_err;
`else
    assign out_err = '0;
`endif

endmodule
